// File: rtl/nsc8_bus_pkg.sv
// rtl/nsc8_bus_pkg.sv - shared constants, sizing helper and occupancy type for the bus receiver
package nsc8_bus_pkg;

    localparam int BUS_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occupancy_t;

    // Address bits needed to index a DEPTH-entry FIFO
    function automatic int clog2_depth(input int depth);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/n_bus_receiver_if.sv
// rtl/n_bus_receiver_if.sv - bus-side and consumer-side signals of the receiver; BUS_RX_PARITY_EN adds parity
interface n_bus_receiver_if
    import nsc8_bus_pkg::*;
#(
    parameter int N     = BUS_W_DEFAULT,
    parameter int DEPTH = 2
);
    logic                          load_bit;
    logic [N-1:0]                  bus_data;
    logic [N-1:0]                  out_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [clog2_depth(DEPTH):0]   count;
    logic                          full;
    logic                          empty;
    logic                          overflow;
`ifdef BUS_RX_PARITY_EN
    logic                          bus_parity;
    logic                          parity_err;

    modport slave (
        input  load_bit, bus_data, bus_parity, out_ready,
        output out_data, out_valid, count, full, empty, overflow, parity_err
    );
    modport master (
        output load_bit, bus_data, bus_parity, out_ready,
        input  out_data, out_valid, count, full, empty, overflow, parity_err
    );
`else
    modport slave (
        input  load_bit, bus_data, out_ready,
        output out_data, out_valid, count, full, empty, overflow
    );
    modport master (
        output load_bit, bus_data, out_ready,
        input  out_data, out_valid, count, full, empty, overflow
    );
`endif
endinterface

// File: rtl/n_bus_fifo_mem.sv
// rtl/n_bus_fifo_mem.sv - DEPTH x N register array, synchronous write, asynchronous read
module n_bus_fifo_mem #(
    parameter int N     = 4,
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [N-1:0]  rd_data
);
    logic [N-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/n_bus_receiver.sv
// rtl/n_bus_receiver.sv - bus sampling FIFO with valid/ready output; BUS_RX_PARITY_EN enables parity check
module n_bus_receiver
    import nsc8_bus_pkg::*;
#(
    parameter int N     = BUS_W_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    n_bus_receiver_if.slave bus
);
    localparam int AW = clog2_depth(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic [N-1:0]  rd_data;
    occupancy_t    occ;
    logic          full;
    logic          empty;
    logic          load_good;
    logic          push;
    logic          pop;

    always_comb begin
        occ = OCC_PARTIAL;
        if (cnt == '0) begin
            occ = OCC_EMPTY;
        end else if (cnt == CW'(DEPTH)) begin
            occ = OCC_FULL;
        end
    end

    assign full  = (occ == OCC_FULL);
    assign empty = (occ == OCC_EMPTY);

`ifdef BUS_RX_PARITY_EN
    logic perr;
    logic parity_bad;

    // Even parity: data bits plus parity bit must XOR to zero
    assign parity_bad = ^{bus.bus_data, bus.bus_parity};
    assign load_good  = bus.load_bit & ~parity_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            perr <= 1'b0;
        end else if (bus.load_bit & parity_bad) begin
            perr <= 1'b1;
        end
    end

    assign bus.parity_err = perr;
`else
    assign load_good = bus.load_bit;
`endif

    // A pop on a full FIFO frees the slot the simultaneous push lands in
    assign pop  = ~empty & bus.out_ready;
    assign push = load_good & (~full | pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (load_good & full & ~pop) begin
                ovf <= 1'b1;
            end
        end
    end

    n_bus_fifo_mem #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (bus.bus_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign bus.out_valid = ~empty;
    assign bus.out_data  = empty ? '0 : rd_data;
    assign bus.count     = cnt;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.overflow  = ovf;

endmodule

// File: tb/tb_n_bus_receiver.sv
// tb/tb_n_bus_receiver.sv - queue-model scoreboard bench for n_bus_receiver; BUS_RX_PARITY_EN adds parity cases
module tb_n_bus_receiver;
    localparam int N     = 4;
    localparam int DEPTH = 2;

    logic clk;
    logic reset;

    n_bus_receiver_if #(.N(N), .DEPTH(DEPTH)) bif();

    n_bus_receiver #(.N(N), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] model_q [$];
    logic [N-1:0] exp_q   [$];
    logic         m_ovf;
    logic         m_perr;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted word must be the next one the model released
    always @(negedge clk) begin
        if (!reset && bif.out_valid && bif.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected actual=%0d expected=none at %0t", bif.out_data, $time);
            end else begin
                logic [N-1:0] e;
                e = exp_q.pop_front();
                if (bif.out_data !== e) begin
                    errors++;
                    $display("FAIL pop_data actual=%0d expected=%0d at %0t", bif.out_data, e, $time);
                end
            end
        end
    end

    task automatic check_state(input string tag);
        int exp_data;
        exp_data = (model_q.size() > 0) ? int'(model_q[0]) : 0;
        check({tag, "_valid"},    int'(bif.out_valid), int'(model_q.size() > 0));
        check({tag, "_data"},     int'(bif.out_data),  exp_data);
        check({tag, "_count"},    int'(bif.count),     model_q.size());
        check({tag, "_full"},     int'(bif.full),      int'(model_q.size() == DEPTH));
        check({tag, "_empty"},    int'(bif.empty),     int'(model_q.size() == 0));
        check({tag, "_overflow"}, int'(bif.overflow),  int'(m_ovf));
`ifdef BUS_RX_PARITY_EN
        check({tag, "_parity_err"}, int'(bif.parity_err), int'(m_perr));
`endif
    endtask

    // One clock: check state left by the previous edge, then drive and model the next edge
    task automatic step(input string tag, input logic ld, input logic [N-1:0] d,
                        input logic rdy, input logic rst, input logic par_ok);
        int  sz;
        logic p;
        @(posedge clk);
        #1;
        check_state(tag);
        reset         = rst;
        bif.load_bit  = ld;
        bif.bus_data  = d;
        bif.out_ready = rdy;
`ifdef BUS_RX_PARITY_EN
        bif.bus_parity = par_ok ? ^d : ~^d;
`endif
        if (rst) begin
            model_q.delete();
            m_ovf  = 1'b0;
            m_perr = 1'b0;
        end else begin
            sz = model_q.size();
            p  = rdy && (sz > 0);
            if (p) exp_q.push_back(model_q.pop_front());
            if (ld && par_ok) begin
                if (sz < DEPTH || p) model_q.push_back(d);
                else                 m_ovf = 1'b1;
            end
            if (ld && !par_ok) m_perr = 1'b1;
        end
    endtask

    initial begin
        reset         = 1'b1;
        bif.load_bit  = 1'b1;
        bif.bus_data  = 4'b1111;
        bif.out_ready = 1'b0;
`ifdef BUS_RX_PARITY_EN
        bif.bus_parity = 1'b0;
`endif
        m_ovf  = 1'b0;
        m_perr = 1'b0;

        step("reset",   1, 4'b1111, 0, 1, 1);
        step("reset",   1, 4'b1111, 0, 1, 1);
        step("single",  1, 4'b1001, 0, 0, 1);
        step("single",  0, 4'b0000, 1, 0, 1);
        step("single",  0, 4'b0000, 0, 0, 1);

        step("fill",    1, 4'b0001, 0, 0, 1);
        step("fill",    1, 4'b0010, 0, 0, 1);
        step("fill",    1, 4'b0011, 0, 0, 1);
        step("fill",    0, 4'b0000, 0, 0, 1);
        step("fill",    0, 4'b0000, 1, 0, 1);
        step("fill",    0, 4'b0000, 1, 0, 1);
        step("fill",    0, 4'b0000, 0, 0, 1);

        step("fpp",     0, 4'b0000, 0, 1, 1);
        step("fpp",     1, 4'b0100, 0, 0, 1);
        step("fpp",     1, 4'b0101, 0, 0, 1);
        step("fpp",     1, 4'b0110, 1, 0, 1);
        step("fpp",     0, 4'b0000, 1, 0, 1);
        step("fpp",     0, 4'b0000, 1, 0, 1);
        step("fpp",     0, 4'b0000, 0, 0, 1);

        for (int i = 0; i < 6; i++) begin
            step("wrap", 1, 4'(4'b1000 + i), 0, 0, 1);
            step("wrap", 0, 4'b0000, 1, 0, 1);
        end

        step("rstmid",  1, 4'b1010, 0, 0, 1);
        step("rstmid",  1, 4'b1011, 0, 0, 1);
        step("rstmid",  1, 4'b1100, 1, 1, 1);
        step("rstmid",  0, 4'b0000, 0, 0, 1);

`ifdef BUS_RX_PARITY_EN
        step("parity",  1, 4'b0111, 0, 0, 0);
        step("parity",  1, 4'b0111, 0, 0, 1);
        step("parity",  0, 4'b0000, 1, 0, 1);
        step("parity",  0, 4'b0000, 0, 1, 1);
        step("parity",  0, 4'b0000, 0, 0, 1);
`endif

        for (int i = 0; i < 400; i++) begin
            logic par;
`ifdef BUS_RX_PARITY_EN
            par = ($urandom_range(0, 7) != 0);
`else
            par = 1'b1;
`endif
            step("rand", 1'($urandom), 4'($urandom), 1'($urandom),
                 ($urandom_range(0, 99) == 0), par);
        end

        for (int i = 0; i < DEPTH + 2; i++) begin
            step("drain", 0, 4'b0000, 1, 0, 1);
        end
        @(negedge clk);
        check("drain_scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
